// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry stall skid buffer
// and branch-redirect flush. Drives a synchronous-read instruction memory.
module fetch_stage #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        INST_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [INST_W-1:0] if_inst,
  output logic [3:0]        if_opcode,
  output logic [ADDR_W-1:0] if_pc1,
  output logic              if_valid
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]  rd_pc_q, rd_pc_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic [ADDR_W-1:0]  pc1_q, pc1_d;
  logic               valid_q, valid_d;
  logic [INST_W-1:0]  skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0]  skid_pc1_q, skid_pc1_d;
  logic               skid_valid_q, skid_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      rd_valid_q   <= 1'b0;
      rd_pc_q      <= '0;
      inst_q       <= '0;
      pc1_q        <= '0;
      valid_q      <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc1_q   <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_valid_q   <= rd_valid_d;
      rd_pc_q      <= rd_pc_d;
      inst_q       <= inst_d;
      pc1_q        <= pc1_d;
      valid_q      <= valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc1_q   <= skid_pc1_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rd_valid_d   = rd_valid_q;
    rd_pc_d      = rd_pc_q;
    inst_d       = inst_q;
    pc1_d        = pc1_q;
    valid_d      = valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc1_d   = skid_pc1_q;
    skid_valid_d = skid_valid_q;

    unique case (state_q)
      StBoot: begin
        pc_d       = pc_q + ADDR_W'(1);
        rd_valid_d = 1'b1;
        rd_pc_d    = pc_q;
        state_d    = StRun;
      end
      StRun, StHold: begin
        if (branch_taken) begin
          // Flush beats stall: in-flight read and any skid word are wrong-path.
          pc_d         = branch_target;
          valid_d      = 1'b0;
          rd_valid_d   = 1'b0;
          skid_valid_d = 1'b0;
          state_d      = StRun;
        end else if (state_q == StRun && !stall) begin
          if (rd_valid_q) begin
            inst_d  = imem_rdata;
            pc1_d   = rd_pc_q + ADDR_W'(1);
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
          pc_d       = pc_q + ADDR_W'(1);
          rd_valid_d = 1'b1;
          rd_pc_d    = pc_q;
        end else if (state_q == StRun) begin
          // Park the returning word; the read issued this cycle is re-issued on release.
          if (rd_valid_q) begin
            skid_inst_d  = imem_rdata;
            skid_pc1_d   = rd_pc_q + ADDR_W'(1);
          end
          skid_valid_d = rd_valid_q;
          rd_valid_d   = 1'b0;
          state_d      = StHold;
        end else if (!stall) begin
          inst_d       = skid_inst_q;
          pc1_d        = skid_pc1_q;
          valid_d      = skid_valid_q;
          skid_valid_d = 1'b0;
          pc_d         = pc_q + ADDR_W'(1);
          rd_valid_d   = 1'b1;
          rd_pc_d      = pc_q;
          state_d      = StRun;
        end else begin
          rd_valid_d = 1'b0;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  assign imem_addr = pc_q;
  assign if_inst   = inst_q;
  assign if_opcode = inst_q[INST_W-1 -: 4];
  assign if_pc1    = pc1_q;
  assign if_valid  = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: two instances (RESET_PC 0 and FE) share stimulus and
// are checked every cycle against a delivery-order model, plus literal spot checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;

  logic [7:0]  addr_a, addr_b, pc1_a, pc1_b;
  logic [15:0] rdata_a, rdata_b, inst_a, inst_b;
  logic [3:0]  opc_a, opc_b;
  logic        valid_a, valid_b;

  logic [15:0] mem [256];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .rst(rst), .imem_addr(addr_a), .imem_rdata(rdata_a), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .if_inst(inst_a),
    .if_opcode(opc_a), .if_pc1(pc1_a), .if_valid(valid_a)
  );

  fetch_stage #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'hFE)) dut_b (
    .clk(clk), .rst(rst), .imem_addr(addr_b), .imem_rdata(rdata_b), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .if_inst(inst_b),
    .if_opcode(opc_b), .if_pc1(pc1_b), .if_valid(valid_b)
  );

  always @(posedge clk) begin
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

  // Model: decode sees mem[nxt], mem[nxt+1], ... in order; 'pending' bubble edges precede the
  // next delivery; a stall freezes everything; a branch restarts at target with one extra bubble.
  typedef struct {
    bit          boot;
    int          pending;
    logic [7:0]  nxt;
    logic        valid;
    logic [15:0] inst;
    logic [7:0]  pc1;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset(logic [7:0] start);
    model_t m;
    m.boot = 1'b1; m.pending = 1; m.nxt = start;
    m.valid = 1'b0; m.inst = '0; m.pc1 = '0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic st, logic br, logic [7:0] tgt);
    model_t r = m;
    if (m.boot) begin
      r.boot = 1'b0;
      r.pending = m.pending - 1;
    end else if (br) begin
      r.valid = 1'b0;
      r.nxt = tgt;
      r.pending = 1;
    end else if (st) begin
      r = m;
    end else if (m.pending > 0) begin
      r.pending = m.pending - 1;
      r.valid = 1'b0;
    end else begin
      r.valid = 1'b1;
      r.inst = mem[m.nxt];
      r.pc1 = m.nxt + 8'd1;
      r.nxt = m.nxt + 8'd1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = model_reset(8'h00);
      mb = model_reset(8'hFE);
    end else begin
      ma = model_step(ma, stall, branch_taken, branch_target);
      mb = model_step(mb, stall, branch_taken, branch_target);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("a_valid", 32'(valid_a), 32'(ma.valid));
    chk("b_valid", 32'(valid_b), 32'(mb.valid));
    if (ma.valid) begin
      chk("a_inst", 32'(inst_a), 32'(ma.inst));
      chk("a_pc1", 32'(pc1_a), 32'(ma.pc1));
      chk("a_opcode", 32'(opc_a), 32'(ma.inst[15:12]));
    end
    if (mb.valid) begin
      chk("b_inst", 32'(inst_b), 32'(mb.inst));
      chk("b_pc1", 32'(pc1_b), 32'(mb.pc1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
    ma = model_reset(8'h00);
    mb = model_reset(8'hFE);

    // Reset, then straight-line fetch (B also shows the FE/FF/00 wrap)
    cyc(2);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_addr_b", 32'(addr_b), 32'hFE);
    rst = 1'b0;
    cyc(1);
    chk("cycle1_valid", 32'(valid_a), 32'd0);
    cyc(1);
    chk("first_valid", 32'(valid_a), 32'd1);
    chk("first_inst", 32'(inst_a), 32'h1000);
    chk("first_pc1", 32'(pc1_a), 32'h01);
    chk("b_first", 32'(inst_b), 32'h10FE);
    chk("b_pc1_ff", 32'(pc1_b), 32'hFF);
    cyc(1);
    chk("second_inst", 32'(inst_a), 32'h1001);
    chk("b_second", 32'(inst_b), 32'h10FF);
    chk("b_pc1_wrap", 32'(pc1_b), 32'h00);
    cyc(1);
    chk("b_third", 32'(inst_b), 32'h1000);
    chk("b_pc1_01", 32'(pc1_b), 32'h01);
    cyc(1);
    chk("pre_stall", 32'(inst_a), 32'h1003);

    // Stall 3 cycles while 1003 is held
    stall = 1'b1;
    cyc(3);
    chk("stall_hold", 32'(inst_a), 32'h1003);
    chk("stall_opcode", 32'(opc_a), 32'h1);
    stall = 1'b0;
    cyc(1);
    chk("post_stall0", 32'(inst_a), 32'h1004);
    cyc(1);
    chk("post_stall1", 32'(inst_a), 32'h1005);

    // Taken branch to 0x40
    branch_taken = 1'b1; branch_target = 8'h40;
    cyc(1);
    branch_taken = 1'b0;
    chk("br_bubble0", 32'(valid_a), 32'd0);
    cyc(1);
    chk("br_bubble1", 32'(valid_a), 32'd0);
    cyc(1);
    chk("br_inst", 32'(inst_a), 32'h1040);
    chk("br_pc1", 32'(pc1_a), 32'h41);

    // Branch while stalled in HOLD with a full skid
    stall = 1'b1;
    cyc(2);
    branch_taken = 1'b1; branch_target = 8'h80;
    cyc(1);
    branch_taken = 1'b0; stall = 1'b0;
    chk("hold_br_bubble0", 32'(valid_a), 32'd0);
    cyc(1);
    chk("hold_br_bubble1", 32'(valid_a), 32'd0);
    cyc(1);
    chk("hold_br_inst", 32'(inst_a), 32'h1080);
    chk("hold_br_pc1", 32'(pc1_a), 32'h81);

    // Mixed stalls and branches, checked by the model
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      branch_target = 8'($urandom_range(0, 255));
      cyc(1);
    end
    branch_taken = 1'b0;

    // Asynchronous reset while in HOLD
    stall = 1'b1;
    cyc(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_inst", 32'(inst_a), 32'h0);
    chk("mid_rst_pc1", 32'(pc1_a), 32'h0);
    chk("mid_rst_addr_a", 32'(addr_a), 32'h00);
    chk("mid_rst_addr_b", 32'(addr_b), 32'hFE);
    stall = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("refetch_inst", 32'(inst_a), 32'h1000);
    chk("refetch_b", 32'(inst_b), 32'h10FE);
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
